// File: rtl/mcu_seq.sv
// mcu_seq: program-buffer instruction sequencer feeding the mcu memory-ALU.
// Host preloads words over valid/ready, pulses start; one instruction issues per cycle.
module mcu_seq #(
   parameter  int op_sz   = 32,
   parameter  int mem_sz  = 10,
   parameter  int prog_sz = 6,
   localparam int IW      = 4 + 2*mem_sz + op_sz
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              load_valid,
   input  logic [IW-1:0]     load_data,
   output logic              load_ready,
   input  logic              load_clr,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [prog_sz:0]  pc,
   output logic [3:0]        op,
   output logic [mem_sz-1:0] op0,
   output logic [op_sz-1:0]  op1,
   output logic [mem_sz-1:0] op2,
   input  logic [op_sz-1:0]  mcu_out,
   output logic              result_valid,
   output logic [op_sz-1:0]  result_data
);

   localparam int              DEPTH  = 2**prog_sz;
   localparam logic [3:0]      OP_RD  = 4'd7;
   localparam logic [3:0]      OP_HLT = 4'd15;
   localparam logic [3:0]      OP_BAD = 4'd9;
   localparam logic [prog_sz:0] PC_ONE = 1;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   typedef struct packed {
      logic [3:0]        op;
      logic [mem_sz-1:0] op0;
      logic [op_sz-1:0]  op1;
      logic [mem_sz-1:0] op2;
   } instr_t;

   logic [IW-1:0]     r_buf [DEPTH];
   state_t            r_state;
   logic [prog_sz:0]  r_count;
   logic [prog_sz:0]  r_pc;
   logic [3:0]        r_op;
   logic [mem_sz-1:0] r_op0;
   logic [op_sz-1:0]  r_op1;
   logic [mem_sz-1:0] r_op2;
   logic              r_done;
   logic              r_err;
   logic              r_rd_issued;
   logic              r_result_valid;
   logic [op_sz-1:0]  r_result_data;

   instr_t            w_word;
   logic              w_load_fire;

   assign w_word      = r_buf[r_pc[prog_sz-1:0]];
   // count never exceeds DEPTH, so its MSB alone marks a full buffer.
   assign load_ready  = (r_state == S_IDLE) && !start && !load_clr && !r_count[prog_sz];
   assign w_load_fire = load_valid && load_ready;

   // NOTE: the program array is deliberately not reset; count bounds every read.
   always_ff @(posedge clk) begin
      if (w_load_fire) r_buf[r_count[prog_sz-1:0]] <= load_data;
   end

   // NOTE: non-blocking assignments throughout so every branch sees pre-edge state.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state        <= S_IDLE;
         r_count        <= '0;
         r_pc           <= '0;
         r_op           <= OP_RD;
         r_op0          <= '0;
         r_op1          <= '0;
         r_op2          <= '0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_rd_issued    <= 1'b0;
         r_result_valid <= 1'b0;
         r_result_data  <= '0;
      end else begin
         // Idle instruction unless a program word is issued below.
         r_op           <= OP_RD;
         r_op0          <= '0;
         r_op1          <= '0;
         r_op2          <= '0;
         r_done         <= 1'b0;
         r_rd_issued    <= 1'b0;
         r_result_valid <= r_rd_issued;
         if (r_rd_issued) r_result_data <= mcu_out;

         unique case (r_state)
            S_IDLE: begin
               if (start && r_count != '0) begin
                  r_pc    <= '0;
                  r_err   <= 1'b0;
                  r_state <= S_RUN;
               end else if (load_clr) begin
                  r_count <= '0;
               end else if (w_load_fire) begin
                  r_count <= r_count + PC_ONE;
               end
            end
            S_RUN: begin
               if (r_pc == r_count || w_word.op == OP_HLT) begin
                  r_state <= S_DONE;
               end else if (w_word.op >= OP_BAD) begin
                  r_err   <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  r_op        <= w_word.op;
                  r_op0       <= w_word.op0;
                  r_op1       <= w_word.op1;
                  r_op2       <= w_word.op2;
                  r_pc        <= r_pc + PC_ONE;
                  r_rd_issued <= (w_word.op == OP_RD);
               end
            end
            S_DONE: begin
               r_done  <= 1'b1;
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign busy         = (r_state == S_RUN);
   assign done         = r_done;
   assign err          = r_err;
   assign pc           = r_pc;
   assign op           = r_op;
   assign op0          = r_op0;
   assign op1          = r_op1;
   assign op2          = r_op2;
   assign result_valid = r_result_valid;
   assign result_data  = r_result_data;

endmodule

// File: tb/tb_mcu_seq.sv
// tb_mcu_seq: table vectors, hand-written corner sequences and random programs for mcu_seq,
// with a small mcu memory stub and an instruction-level reference model.
module tb_mcu_seq;

   localparam int OP_SZ   = 32;
   localparam int MEM_SZ  = 10;
   localparam int PROG_SZ = 6;
   localparam int IW      = 4 + 2*MEM_SZ + OP_SZ;

   typedef struct packed {
      logic [3:0]        op;
      logic [MEM_SZ-1:0] op0;
      logic [OP_SZ-1:0]  op1;
      logic [MEM_SZ-1:0] op2;
   } tb_instr_t;

   typedef struct {
      string            name;
      int               n;
      tb_instr_t        w [4];
      int               exp_pc;
      bit               exp_err;
      int               exp_nres;
      logic [OP_SZ-1:0] exp_res0;
      bit               rerun;
   } vec_t;

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic              load_valid = 1'b0;
   logic [IW-1:0]     load_data = '0;
   logic              load_clr = 1'b0;
   logic              start = 1'b0;
   logic              load_ready, busy, done, err, result_valid;
   logic [PROG_SZ:0]  pc;
   logic [3:0]        op;
   logic [MEM_SZ-1:0] op0, op2;
   logic [OP_SZ-1:0]  op1, mcu_out, result_data;

   int                checks = 0;
   int                errors = 0;
   int                bad_op = 0;
   logic [OP_SZ-1:0]  q_res [$];
   logic [OP_SZ-1:0]  mcu_mem [1<<MEM_SZ];
   logic [OP_SZ-1:0]  ref_mem [1<<MEM_SZ];
   tb_instr_t         prog [64];
   int                prog_n;
   vec_t              tbl [6];

   mcu_seq #(.op_sz(OP_SZ), .mem_sz(MEM_SZ), .prog_sz(PROG_SZ)) dut (
      .clk(clk), .reset(reset), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .load_clr(load_clr), .start(start), .busy(busy),
      .done(done), .err(err), .pc(pc), .op(op), .op0(op0), .op1(op1), .op2(op2),
      .mcu_out(mcu_out), .result_valid(result_valid), .result_data(result_data)
   );

   always #5 clk = ~clk;

   // mcu stub: writes at the edge, reads combinationally.
   initial for (int i = 0; i < (1<<MEM_SZ); i++) mcu_mem[i] <= '0;
   assign mcu_out = mcu_mem[op0];
   always @(posedge clk) begin
      case (op)
         4'd8:    mcu_mem[op0] <= op1;
         4'd0:    mcu_mem[op2] <= mcu_mem[op0] + mcu_mem[op1[MEM_SZ-1:0]];
         default: ;
      endcase
   end

   always @(negedge clk) begin
      if (result_valid) q_res.push_back(result_data);
      if (op >= 4'd9) bad_op++;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic tb_instr_t mk(input int o, input int a0, input logic [OP_SZ-1:0] d1, input int a2);
      return '{op: 4'(o), op0: MEM_SZ'(a0), op1: d1, op2: MEM_SZ'(a2)};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_buf();
      load_clr = 1'b1;
      step();
      load_clr = 1'b0;
   endtask

   task automatic load_prog();
      load_valid = 1'b1;
      for (int i = 0; i < prog_n; i++) begin
         load_data = prog[i];
         step();
      end
      load_valid = 1'b0;
   endtask

   // Instruction-level model: execute words in order until end, halt or illegal op.
   task automatic ref_run(output int m, output bit e, output logic [OP_SZ-1:0] res [$]);
      tb_instr_t w;
      m = 0;
      e = 1'b0;
      res.delete();
      while (m < prog_n) begin
         w = prog[m];
         if (w.op == 4'd15) break;
         if (w.op >= 4'd9) begin
            e = 1'b1;
            break;
         end
         case (w.op)
            4'd8:    ref_mem[w.op0] = w.op1;
            4'd0:    ref_mem[w.op2] = ref_mem[w.op0] + ref_mem[w.op1[MEM_SZ-1:0]];
            4'd7:    res.push_back(ref_mem[w.op0]);
            default: ;
         endcase
         m++;
      end
   endtask

   task automatic run_check(input string tag, input int exp_pc, input bit exp_err,
                            input logic [OP_SZ-1:0] exp_res [$]);
      int lat;
      q_res.delete();
      start = 1'b1;
      #1;
      check($sformatf("%s load_ready_with_start", tag), load_ready, 0);
      step();
      start      = 1'b0;
      load_valid = 1'b0;
      check($sformatf("%s busy", tag), busy, 1);
      check($sformatf("%s err_cleared", tag), err, 0);
      lat = 0;
      do begin
         step();
         lat++;
      end while (!done && lat < 300);
      check($sformatf("%s done_latency", tag), lat, exp_pc + 2);
      check($sformatf("%s pc", tag), pc, exp_pc);
      check($sformatf("%s err", tag), err, exp_err);
      check($sformatf("%s n_results", tag), q_res.size(), exp_res.size());
      for (int i = 0; i < exp_res.size() && i < q_res.size(); i++)
         check($sformatf("%s result%0d", tag, i), q_res[i], exp_res[i]);
      step();
      check($sformatf("%s done_one_cycle", tag), {busy, done}, 2'b00);
   endtask

   task automatic set_vec(input int idx, input string name, input int n,
                          input tb_instr_t w0, input tb_instr_t w1, input tb_instr_t w2, input tb_instr_t w3,
                          input int pc_e, input bit err_e, input int nres, input logic [OP_SZ-1:0] res0,
                          input bit rerun);
      tbl[idx].name     = name;
      tbl[idx].n        = n;
      tbl[idx].w[0]     = w0;
      tbl[idx].w[1]     = w1;
      tbl[idx].w[2]     = w2;
      tbl[idx].w[3]     = w3;
      tbl[idx].exp_pc   = pc_e;
      tbl[idx].exp_err  = err_e;
      tbl[idx].exp_nres = nres;
      tbl[idx].exp_res0 = res0;
      tbl[idx].rerun    = rerun;
   endtask

   task automatic gen_prog();
      int r, a, b, c;
      prog_n = $urandom_range(1, 12);
      for (int i = 0; i < prog_n; i++) begin
         r = $urandom_range(0, 19);
         a = $urandom_range(0, 7);
         b = $urandom_range(0, 7);
         c = $urandom_range(0, 7);
         if (r < 6)                 prog[i] = mk(8, a, $urandom, 0);
         else if (r < 11 || r > 17) prog[i] = mk(7, a, 0, 0);
         else if (r < 16)           prog[i] = mk(0, a, 32'(b), c);
         else if (r == 16)          prog[i] = mk(15, 0, 0, 0);
         else                       prog[i] = mk(9 + $urandom_range(0, 5), 0, 0, 0);
      end
   endtask

   initial begin
      int               m;
      bit               e;
      bit               ok;
      logic [OP_SZ-1:0] res [$];
      logic [OP_SZ-1:0] eq [$];
      tb_instr_t        z;

      for (int i = 0; i < (1<<MEM_SZ); i++) ref_mem[i] = '0;
      z = mk(0, 0, 0, 0);
      // op1 carries data for op 8 and the second source address for op 0.
      set_vec(0, "basic",       4, mk(8,1,5,0), mk(8,2,7,0), mk(0,1,2,3), mk(7,3,0,0), 4, 0, 1, 12, 0);
      set_vec(1, "rd_after_wr", 2, mk(8,5,33,0), mk(7,5,0,0), z, z,                      2, 0, 1, 33, 0);
      set_vec(2, "halt",        3, mk(8,4,9,0), mk(15,0,0,0), mk(7,4,0,0), z,            1, 0, 0, 0,  0);
      set_vec(3, "halt_first",  2, mk(15,0,0,0), mk(7,1,0,0), z, z,                      0, 0, 0, 0,  0);
      set_vec(4, "illegal",     2, mk(10,0,0,0), mk(7,0,0,0), z, z,                      0, 1, 0, 0,  1);
      set_vec(5, "illegal_mid", 3, mk(7,2,0,0), mk(14,0,0,0), mk(7,1,0,0), z,            1, 1, 1, 7,  0);

      step();
      step();
      reset = 1'b0;
      #1;
      check("reset busy_done_err", {busy, done, err}, 3'b000);
      check("reset pc", pc, 0);
      check("reset issue", {op, op0, op1, op2}, {4'd7, 52'd0});
      check("reset result", {result_valid, result_data}, 33'd0);
      check("reset load_ready", load_ready, 1);

      foreach (tbl[t]) begin
         clear_buf();
         prog_n = tbl[t].n;
         for (int i = 0; i < prog_n; i++) prog[i] = tbl[t].w[i];
         load_prog();
         eq.delete();
         if (tbl[t].exp_nres > 0) eq.push_back(tbl[t].exp_res0);
         for (int r = 0; r <= int'(tbl[t].rerun); r++) begin
            ref_run(m, e, res);
            run_check($sformatf("%s#%0d", tbl[t].name, r), tbl[t].exp_pc, tbl[t].exp_err, eq);
         end
      end

      // Full buffer: 64 reads accepted, 65th offer refused.
      clear_buf();
      prog_n = 64;
      for (int i = 0; i < 64; i++) prog[i] = mk(7, i, 0, 0);
      ok = 1'b1;
      load_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         load_data = prog[i];
         #1;
         if (!load_ready) ok = 1'b0;
         step();
      end
      check("full ready_during_fill", ok, 1);
      load_data = mk(15, 0, 0, 0);
      #1;
      check("full ready_low", load_ready, 0);
      step();
      load_valid = 1'b0;
      ref_run(m, e, res);
      run_check("full64", m, e, res);
      load_clr = 1'b1;
      #1;
      check("clr ready_low_while_clr", load_ready, 0);
      step();
      load_clr = 1'b0;
      #1;
      check("clr ready_high", load_ready, 1);

      // start with an empty buffer is ignored.
      start = 1'b1;
      step();
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (busy || done) ok = 1'b1;
         step();
      end
      check("empty_start ignored", ok, 0);

      // start and load_valid together: the load loses, the 2-word run proceeds.
      clear_buf();
      prog_n = 2;
      prog[0] = mk(7, 1, 0, 0);
      prog[1] = mk(7, 2, 0, 0);
      load_prog();
      load_valid = 1'b1;
      load_data  = mk(7, 5, 0, 0);
      ref_run(m, e, res);
      run_check("start_vs_load", m, e, res);

      for (int k = 0; k < 25; k++) begin
         gen_prog();
         clear_buf();
         load_prog();
         ref_run(m, e, res);
         run_check($sformatf("rand%0d", k), m, e, res);
      end

      // Reset while instruction 2 of 5 is on the mcu ports.
      clear_buf();
      prog_n = 5;
      for (int i = 0; i < 5; i++) prog[i] = mk(7, i, 0, 0);
      load_prog();
      start = 1'b1;
      step();
      start = 1'b0;
      step();
      step();
      step();
      check("midrst op_is_instr2", op0, 2);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("midrst busy_done_err", {busy, done, err}, 3'b000);
      check("midrst pc", pc, 0);
      check("midrst issue", {op, op0, op1, op2}, {4'd7, 52'd0});
      check("midrst result_valid", result_valid, 0);
      start = 1'b1;
      step();
      start = 1'b0;
      ok = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (busy || done) ok = 1'b1;
         step();
      end
      check("midrst start_ignored", ok, 0);
      check("midrst load_ready", load_ready, 1);

      check("no_illegal_or_halt_op_forwarded", bad_op, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
